// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the LEGv8 decode stage.
package decode_pkg;

  // Internal datapath width for PC and immediate; the stage's XLEN must not exceed it.
  localparam int DEC_XLEN = 64;

  typedef enum logic [2:0] {
    TYPE_R       = 3'd0,
    TYPE_I       = 3'd1,
    TYPE_D       = 3'd2,
    TYPE_B       = 3'd3,
    TYPE_CB      = 3'd4,
    TYPE_ILLEGAL = 3'd5
  } instr_type_t;

  // Opcodes, each at the width of the field it is matched against.
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    instr_type_t         itype;
    logic [10:0]         opcode;
    logic [4:0]          rm;
    logic [4:0]          rn;
    logic [4:0]          rd;
    logic [DEC_XLEN-1:0] imm;
    logic                illegal;
  } decoded_t;

  // Format classification; earlier matches take priority.
  function automatic instr_type_t classify(input logic [31:0] instr);
    instr_type_t t;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      t = TYPE_D;
    end else if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
                 instr[31:21] == OP_AND || instr[31:21] == OP_ORR) begin
      t = TYPE_R;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      t = TYPE_I;
    end else if (instr[31:26] == OP_B) begin
      t = TYPE_B;
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      t = TYPE_CB;
    end else begin
      t = TYPE_ILLEGAL;
    end
    return t;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational LEGv8 field extractor: raw instruction + PC -> decoded_t.
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [DEC_XLEN-1:0] pc,
  output decoded_t            dec
);

  instr_type_t itype;
  assign itype = classify(instr);

  // Pull out the fields that exist for this format; everything else stays zero.
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.opcode  = instr[31:21];
    dec.itype   = itype;
    dec.illegal = 1'b0;
    case (itype)
      TYPE_R: begin
        dec.rm  = instr[20:16];
        dec.rn  = instr[9:5];
        dec.rd  = instr[4:0];
        dec.imm = {{(DEC_XLEN-6){1'b0}}, instr[15:10]};
      end
      TYPE_I: begin
        dec.rn  = instr[9:5];
        dec.rd  = instr[4:0];
        dec.imm = {{(DEC_XLEN-12){1'b0}}, instr[21:10]};
      end
      TYPE_D: begin
        dec.rn  = instr[9:5];
        dec.rd  = instr[4:0];
        dec.imm = {{(DEC_XLEN-9){instr[20]}}, instr[20:12]};
      end
      TYPE_B: begin
        dec.imm = {{(DEC_XLEN-26){instr[25]}}, instr[25:0]};
      end
      TYPE_CB: begin
        dec.rd  = instr[4:0];
        dec.imm = {{(DEC_XLEN-19){instr[23]}}, instr[23:5]};
      end
      default: begin
        dec.itype   = TYPE_ILLEGAL;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered, back-pressured decode stage: decodes on entry and buffers
// up to DEPTH decoded entries between fetch and register-read.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,  // must not exceed DEC_XLEN
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_type,
  output logic [10:0]      out_opcode,
  output logic [REG_W-1:0] out_rm_num,
  output logic [REG_W-1:0] out_rn_num,
  output logic [REG_W-1:0] out_rd_num,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  decoded_t             in_dec;
  decoded_t             mem_q [DEPTH];
  decoded_t             head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 in_ready_q, in_ready_d;
  logic                 push, pop;

  instr_field_decode u_field_decode (
    .instr (in_instr),
    .pc    (DEC_XLEN'(in_pc)),
    .dec   (in_dec)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  // Next pointer/occupancy state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Space flag is precomputed from next occupancy so in_ready has no path from out_ready.
    in_ready_d = (count_d < CNT_W'(DEPTH));
  end

  // Control state; reset empties the buffer and holds off fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Entry storage; contents are don't-care when unoccupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_dec;
    end
  end

  // Head entry drives the outputs; zeros whenever the buffer is empty.
  always_comb begin
    out_pc      = '0;
    out_type    = '0;
    out_opcode  = '0;
    out_rm_num  = '0;
    out_rn_num  = '0;
    out_rd_num  = '0;
    out_imm     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = head.pc[XLEN-1:0];
      out_type    = head.itype;
      out_opcode  = head.opcode;
      out_rm_num  = REG_W'(head.rm);
      out_rn_num  = REG_W'(head.rn);
      out_rd_num  = REG_W'(head.rd);
      out_imm     = head.imm[XLEN-1:0];
      out_illegal = head.illegal;
    end
  end

endmodule
